// File: rtl/sram_fifo_arbiter.sv
// Runs an external asynchronous 16-bit SRAM as a circular FIFO, arbitrating single-word writes and reads.
// Optional build macro SRAM_FIFO_DROP_ON_FULL_EN: discard (and count) writes offered while full instead of stalling.
module sram_fifo_arbiter #(
    parameter int DEPTH_BITS         = 20,
    parameter int ALMOST_FULL_MARGIN = 16
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  SOFT_RST,
    input  logic                  WR_REQ,
    input  logic [15:0]           WR_DATA,
    output logic                  WR_ACK,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    input  logic                  RD_REQ,
    output logic [15:0]           RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY,
    output logic [DEPTH_BITS:0]   FILL_CNT,
    output logic [DEPTH_BITS-1:0] SRAM_A,
    input  logic [15:0]           SRAM_IO_I,
    output logic [15:0]           SRAM_IO_O,
    output logic                  SRAM_IO_T,
    output logic                  SRAM_WE_B,
    output logic                  SRAM_OE_B,
    output logic                  SRAM_CE1_B,
    output logic                  SRAM_BHE_B,
`ifdef SRAM_FIFO_DROP_ON_FULL_EN
    output logic [7:0]            LOST_CNT,
`endif
    output logic                  SRAM_BLE_B
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_ADDR   = 3'd4,
        RD_CAPT   = 3'd5
    } state_t;

    localparam logic [DEPTH_BITS:0]   CAPACITY_C = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0]   FILL_ONE_C = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] PTR_ONE_C  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [31:0]           MARGIN_C   = ALMOST_FULL_MARGIN;

    function automatic logic almost_full_f(input logic [DEPTH_BITS:0] fill);
        logic [DEPTH_BITS:0] free_v;
        free_v = CAPACITY_C - fill;
        return (32'(free_v) <= MARGIN_C);
    endfunction

    state_t                state_r, state_s;
    logic [DEPTH_BITS-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_BITS:0]   fill_r, fill_s;
    logic                  full_r, empty_r, af_r;
    logic                  wr_ack_r, wr_ack_s;
    logic                  rd_valid_r;
    logic [15:0]           rd_data_r;
    logic [DEPTH_BITS-1:0] sram_a_r, sram_a_s;
    logic [15:0]           io_o_r, io_o_s;
    logic                  io_t_r, io_t_s;
    logic                  we_b_r, we_b_s;
    logic                  oe_b_r, oe_b_s;
    logic                  ce_b_r;
    logic                  last_wr_r;
    logic                  wr_elig_s, rd_elig_s, drop_s;
    logic                  wr_grant_s, rd_grant_s, wr_commit_s, rd_commit_s;

    // Arbitration, next state and next values of every registered strobe/output
    always_comb begin
        wr_elig_s = WR_REQ && !full_r;
        rd_elig_s = RD_REQ && !empty_r;
        drop_s    = 1'b0;
`ifdef SRAM_FIFO_DROP_ON_FULL_EN
        // wr_ack_r blocks a second drop while the writer is still seeing the previous ack
        drop_s    = (state_r == IDLE) && WR_REQ && full_r && !wr_ack_r;
`endif
        state_s   = state_r;
        case (state_r)
            IDLE: begin
                if (drop_s) begin
                    state_s = IDLE;
                end else if (wr_elig_s && rd_elig_s) begin
                    state_s = last_wr_r ? RD_ADDR : WR_SETUP;
                end else if (wr_elig_s) begin
                    state_s = WR_SETUP;
                end else if (rd_elig_s) begin
                    state_s = RD_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_SETUP:  state_s = WR_STROBE;
            WR_STROBE: state_s = WR_HOLD;
            WR_HOLD:   state_s = IDLE;
            RD_ADDR:   state_s = RD_CAPT;
            RD_CAPT:   state_s = IDLE;
            default:   state_s = IDLE;
        endcase

        wr_grant_s  = (state_r == IDLE) && (state_s == WR_SETUP);
        rd_grant_s  = (state_r == IDLE) && (state_s == RD_ADDR);
        wr_commit_s = (state_r == WR_STROBE);
        rd_commit_s = (state_r == RD_ADDR);

        if (wr_commit_s) begin
            fill_s = fill_r + FILL_ONE_C;
        end else if (rd_commit_s) begin
            fill_s = fill_r - FILL_ONE_C;
        end else begin
            fill_s = fill_r;
        end

        if (wr_grant_s) begin
            sram_a_s = wr_ptr_r;
        end else if (rd_grant_s) begin
            sram_a_s = rd_ptr_r;
        end else begin
            sram_a_s = sram_a_r;
        end

        if (wr_grant_s) begin
            io_o_s = WR_DATA;
        end else begin
            io_o_s = io_o_r;
        end

        // Bus is driven only across the whole write window, so it is released before OE_B can fall
        io_t_s   = !((state_s == WR_SETUP) || (state_s == WR_STROBE) || (state_s == WR_HOLD));
        we_b_s   = (state_s != WR_STROBE);
        oe_b_s   = !((state_s == RD_ADDR) || (state_s == RD_CAPT));
        wr_ack_s = (state_s == WR_HOLD) || drop_s;
    end

    // State, pointers, fill/status flags and registered SRAM interface
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || SOFT_RST) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fill_r     <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            af_r       <= 1'b0;
            wr_ack_r   <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 16'h0000;
            sram_a_r   <= '0;
            io_o_r     <= 16'h0000;
            io_t_r     <= 1'b1;
            we_b_r     <= 1'b1;
            oe_b_r     <= 1'b1;
            ce_b_r     <= 1'b1;
            last_wr_r  <= 1'b1;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_commit_s ? (wr_ptr_r + PTR_ONE_C) : wr_ptr_r;
            rd_ptr_r   <= rd_commit_s ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
            fill_r     <= fill_s;
            full_r     <= (fill_s == CAPACITY_C);
            empty_r    <= (fill_s == {(DEPTH_BITS+1){1'b0}});
            af_r       <= almost_full_f(fill_s);
            wr_ack_r   <= wr_ack_s;
            rd_valid_r <= (state_r == RD_CAPT);
            rd_data_r  <= (state_r == RD_CAPT) ? SRAM_IO_I : rd_data_r;
            sram_a_r   <= sram_a_s;
            io_o_r     <= io_o_s;
            io_t_r     <= io_t_s;
            we_b_r     <= we_b_s;
            oe_b_r     <= oe_b_s;
            ce_b_r     <= 1'b0;
            last_wr_r  <= wr_grant_s ? 1'b1 : (rd_grant_s ? 1'b0 : last_wr_r);
        end
    end

`ifdef SRAM_FIFO_DROP_ON_FULL_EN
    logic [7:0] lost_r;

    // Saturating count of words discarded while full
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || SOFT_RST) begin
            lost_r <= 8'd0;
        end else if (drop_s && (lost_r != 8'hFF)) begin
            lost_r <= lost_r + 8'd1;
        end else begin
            lost_r <= lost_r;
        end
    end

    assign LOST_CNT = lost_r;
`endif

    assign WR_ACK      = wr_ack_r;
    assign FULL        = full_r;
    assign ALMOST_FULL = af_r;
    assign EMPTY       = empty_r;
    assign FILL_CNT    = fill_r;
    assign RD_DATA     = rd_data_r;
    assign RD_VALID    = rd_valid_r;
    assign SRAM_A      = sram_a_r;
    assign SRAM_IO_O   = io_o_r;
    assign SRAM_IO_T   = io_t_r;
    assign SRAM_WE_B   = we_b_r;
    assign SRAM_OE_B   = oe_b_r;
    assign SRAM_CE1_B  = ce_b_r;
    assign SRAM_BHE_B  = ce_b_r;
    assign SRAM_BLE_B  = ce_b_r;

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Directed, table-driven bench for sram_fifo_arbiter at DEPTH_BITS=4 with a behavioural SRAM.
module tb_sram_fifo_arbiter;

    localparam int DB = 4;

    logic          bus_clk = 1'b0;
    logic          bus_rst = 1'b1;
    logic          soft_rst = 1'b0;
    logic          wr_req = 1'b0;
    logic [15:0]   wr_data = 16'h0000;
    logic          wr_ack, full, almost_full;
    logic          rd_req = 1'b0;
    logic [15:0]   rd_data;
    logic          rd_valid, empty;
    logic [DB:0]   fill_cnt;
    logic [DB-1:0] sram_a;
    logic [15:0]   sram_io_i, sram_io_o;
    logic          sram_io_t, we_b, oe_b, ce1_b, bhe_b, ble_b;
`ifdef SRAM_FIFO_DROP_ON_FULL_EN
    logic [7:0]    lost_cnt;
`endif

    sram_fifo_arbiter #(.DEPTH_BITS(DB), .ALMOST_FULL_MARGIN(16)) dut (
        .BUS_CLK(bus_clk), .BUS_RST(bus_rst), .SOFT_RST(soft_rst),
        .WR_REQ(wr_req), .WR_DATA(wr_data), .WR_ACK(wr_ack),
        .FULL(full), .ALMOST_FULL(almost_full),
        .RD_REQ(rd_req), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .EMPTY(empty), .FILL_CNT(fill_cnt), .SRAM_A(sram_a),
        .SRAM_IO_I(sram_io_i), .SRAM_IO_O(sram_io_o), .SRAM_IO_T(sram_io_t),
        .SRAM_WE_B(we_b), .SRAM_OE_B(oe_b), .SRAM_CE1_B(ce1_b), .SRAM_BHE_B(bhe_b),
`ifdef SRAM_FIFO_DROP_ON_FULL_EN
        .LOST_CNT(lost_cnt),
`endif
        .SRAM_BLE_B(ble_b)
    );

    always #5 bus_clk = ~bus_clk;

    logic [15:0] mem [16];
    always @(posedge bus_clk) begin
        if (!we_b && !ce1_b) mem[sram_a] <= sram_io_t ? 16'hBAD0 : sram_io_o;
    end
    assign sram_io_i = (!oe_b && sram_io_t) ? mem[sram_a] : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: WE_B low exactly one cycle; bus never driven while OE_B low
    int we_run = 0;
    always @(negedge bus_clk) begin
        if (!we_b) begin
            we_run++;
        end else if (we_run != 0) begin
            chk("we_b_low_width", we_run, 1);
            we_run = 0;
        end
        if (!oe_b) chk("io_t_while_oe", {31'd0, sram_io_t}, 1);
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic pulse_soft_rst();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
    endtask

    // One write from IDLE; returns cycles to WR_ACK (-1 on timeout) and address seen under WE_B low
    task automatic do_wr(input logic [15:0] d, output int lat, output logic [DB-1:0] a);
        wr_req = 1'b1; wr_data = d; lat = -1; a = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (!we_b) a = sram_a;
            if (wr_ack) begin lat = c; break; end
        end
        wr_req = 1'b0;
        tick();
    endtask

    // One read from IDLE; returns cycles to RD_VALID, data and address seen under OE_B low
    task automatic do_rd(output int lat, output logic [15:0] d, output logic [DB-1:0] a);
        rd_req = 1'b1; lat = -1; d = '0; a = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (!oe_b && rd_req) begin a = sram_a; rd_req = 1'b0; end
            if (rd_valid) begin lat = c; d = rd_data; break; end
        end
        rd_req = 1'b0;
    endtask

    typedef struct {
        logic          is_wr;
        logic [15:0]   data;
        logic [DB-1:0] exp_addr;
        logic [DB:0]   exp_fill;
        logic          exp_empty;
    } vec_t;

    vec_t          tbl[8];
    int            lat;
    logic [DB-1:0] addr;
    logic [15:0]   rdat;
    logic          saw;
    int            ng, nr, nack;
    logic [7:0]    gkind[4];
    int            gcyc[4];
    logic [15:0]   rq[2];
    logic          prev_oe, prev_iot;

    initial begin
        tbl[0] = '{1'b1, 16'h0001, 4'd0, 5'd1, 1'b0};
        tbl[1] = '{1'b1, 16'h0002, 4'd1, 5'd2, 1'b0};
        tbl[2] = '{1'b1, 16'h0003, 4'd2, 5'd3, 1'b0};
        tbl[3] = '{1'b1, 16'h0004, 4'd3, 5'd4, 1'b0};
        tbl[4] = '{1'b0, 16'h0001, 4'd0, 5'd3, 1'b0};
        tbl[5] = '{1'b0, 16'h0002, 4'd1, 5'd2, 1'b0};
        tbl[6] = '{1'b0, 16'h0003, 4'd2, 5'd1, 1'b0};
        tbl[7] = '{1'b0, 16'h0004, 4'd3, 5'd0, 1'b1};

        // Reset values, sampled while reset is still asserted
        tick(); tick();
        chk("rst_we_b", {31'd0, we_b}, 1);
        chk("rst_oe_b", {31'd0, oe_b}, 1);
        chk("rst_io_t", {31'd0, sram_io_t}, 1);
        chk("rst_fill", {27'd0, fill_cnt}, 0);
        chk("rst_flags", {28'd0, empty, full, almost_full, wr_ack}, 32'h8);
        chk("rst_rd", {15'd0, rd_valid, rd_data}, 0);
        chk("rst_addr", {28'd0, sram_a}, 0);
        chk("rst_ce_bhe_ble", {29'd0, ce1_b, bhe_b, ble_b}, 32'h7);
        bus_rst = 1'b0;
        tick();
        chk("ce_bhe_ble_run", {29'd0, ce1_b, bhe_b, ble_b}, 0);
        chk("af_at_fill0", {31'd0, almost_full}, 1);

        // Read request on empty FIFO is ignored
        rd_req = 1'b1; saw = 1'b0;
        for (int c = 0; c < 8; c++) begin tick(); if (rd_valid || !oe_b) saw = 1'b1; end
        rd_req = 1'b0;
        chk("empty_read_ignored", {31'd0, saw}, 0);

        // Table: 4 writes then 4 reads
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_wr) begin
                do_wr(tbl[i].data, lat, addr);
                chk($sformatf("v%0d_wr_lat", i), lat, 3);
            end else begin
                do_rd(lat, rdat, addr);
                chk($sformatf("v%0d_rd_lat", i), lat, 3);
                chk($sformatf("v%0d_rd_data", i), {16'd0, rdat}, {16'd0, tbl[i].data});
            end
            chk($sformatf("v%0d_addr", i), {28'd0, addr}, {28'd0, tbl[i].exp_addr});
            chk($sformatf("v%0d_fill", i), {27'd0, fill_cnt}, {27'd0, tbl[i].exp_fill});
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].exp_empty});
        end

        // Fill to capacity
        pulse_soft_rst();
        for (int i = 0; i < 16; i++) begin
            do_wr(16'h0100 + 16'(i), lat, addr);
            chk($sformatf("fill%0d_lat", i), lat, 3);
            chk($sformatf("fill%0d_addr", i), {28'd0, addr}, i);
        end
        chk("full_fill", {27'd0, fill_cnt}, 16);
        chk("full_flags", {29'd0, full, almost_full, empty}, 32'h6);

`ifndef SRAM_FIFO_DROP_ON_FULL_EN
        // 17th write stalls until a read frees space, then lands at address 0
        wr_req = 1'b1; wr_data = 16'hBEEF; saw = 1'b0;
        for (int c = 0; c < 10; c++) begin tick(); if (wr_ack || !we_b) saw = 1'b1; end
        chk("full_write_stalled", {31'd0, saw}, 0);
        rd_req = 1'b1; lat = -1; nr = -1; addr = '1; rdat = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (!oe_b) rd_req = 1'b0;
            if (rd_valid) begin nr = c; rdat = rd_data; end
            if (wr_ack) begin lat = c; addr = sram_a; saw = full; break; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        chk("bp_rd_lat", nr, 3);
        chk("bp_rd_data", {16'd0, rdat}, 32'h0100);
        chk("bp_wr_lat", lat, 6);
        chk("bp_wr_wrap_addr", {28'd0, addr}, 0);
        chk("bp_full_again", {31'd0, saw}, 1);

        // Alternating grants with both sides requesting
        pulse_soft_rst();
        do_wr(16'hA001, lat, addr);
        do_wr(16'hA002, lat, addr);
        wr_req = 1'b1; wr_data = 16'hB001; rd_req = 1'b1;
        ng = 0; nr = 0; nack = 0; prev_oe = 1'b1; prev_iot = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ng < 4 && !oe_b && prev_oe) begin gkind[ng] = "R"; gcyc[ng] = c; ng++; end
            if (ng < 4 && !sram_io_t && prev_iot) begin gkind[ng] = "W"; gcyc[ng] = c; ng++; end
            prev_oe = oe_b; prev_iot = sram_io_t;
            if (rd_valid && nr < 2) begin rq[nr] = rd_data; nr++; end
            if (wr_ack) begin nack++; wr_data = 16'hB002; if (nack == 2) wr_req = 1'b0; end
            if (ng == 4) rd_req = 1'b0;
            if (nack == 2 && nr == 2) break;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        chk("alt_grant_count", ng, 4);
        chk("alt_order", {gkind[0], gkind[1], gkind[2], gkind[3]}, {"R", "W", "R", "W"});
        chk("alt_period", gcyc[2] - gcyc[0], 7);
        chk("alt_rd0", {16'd0, rq[0]}, 32'hA001);
        chk("alt_rd1", {16'd0, rq[1]}, 32'hA002);
        chk("alt_fill", {27'd0, fill_cnt}, 2);
        do_rd(lat, rdat, addr);
        chk("alt_drain0", {12'd0, addr, rdat}, {12'd0, 4'd2, 16'hB001});
        do_rd(lat, rdat, addr);
        chk("alt_drain1", {12'd0, addr, rdat}, {12'd0, 4'd3, 16'hB002});
`else
        // Writes offered while full are acked next cycle and counted
        for (int i = 16; i < 20; i++) begin
            do_wr(16'h0100 + 16'(i), lat, addr);
            chk($sformatf("drop%0d_lat", i), lat, 1);
        end
        chk("drop_lost", {24'd0, lost_cnt}, 4);
        chk("drop_fill", {27'd0, fill_cnt}, 16);
`endif

        // Pointer wrap: 40 write/read pairs preserve order
        pulse_soft_rst();
        for (int i = 0; i < 40; i++) begin
            do_wr(16'hC000 + 16'(i), lat, addr);
            chk($sformatf("wrap%0d_wa", i), {28'd0, addr}, i % 16);
            do_rd(lat, rdat, addr);
            chk($sformatf("wrap%0d_ra", i), {28'd0, addr}, i % 16);
            chk($sformatf("wrap%0d_rd", i), {16'd0, rdat}, 32'hC000 + i);
        end

        // Soft reset during WR_STROBE aborts the write
        pulse_soft_rst();
        do_wr(16'h1111, lat, addr);
        do_wr(16'h2222, lat, addr);
        wr_req = 1'b1; wr_data = 16'h3333;
        tick(); tick();
        chk("abort_in_strobe", {31'd0, we_b}, 0);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0; wr_req = 1'b0;
        chk("abort_we_io", {30'd0, we_b, sram_io_t}, 32'h3);
        chk("abort_no_ack", {31'd0, wr_ack}, 0);
        chk("abort_fill", {27'd0, fill_cnt}, 0);
        chk("abort_empty", {31'd0, empty}, 1);
        tick();
        chk("abort_no_late_ack", {31'd0, wr_ack}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_fifo_arbiter.md
Name: sram_fifo_arbiter

Overview:
Controller that runs the board's external 1M x 16 asynchronous SRAM as a circular FIFO. It arbitrates single-word accesses between the write side (receiver/TDC/trigger data merger) and the read side (USB fast-read path). It generates all SRAM strobes with fixed, safe timing and exposes fill level and full/empty status to the bus register block.

Parameters:
DEPTH_BITS, 20, SRAM address width; FIFO capacity is 2^DEPTH_BITS words
ALMOST_FULL_MARGIN, 16, ALMOST_FULL asserts when free words <= this value

Ports:
BUS_CLK  in  1  single system clock; all logic on rising edge
BUS_RST  in  1  synchronous, active-high reset
SOFT_RST  in  1  synchronous pointer/counter clear from register block; same effect as BUS_RST
WR_REQ  in  1  write request, level; held until WR_ACK
WR_DATA  in  16  write word; stable while WR_REQ is high
WR_ACK  out  1  one-cycle pulse: word committed to SRAM
FULL  out  1  fill == 2^DEPTH_BITS
ALMOST_FULL  out  1  (2^DEPTH_BITS - fill) <= ALMOST_FULL_MARGIN
RD_REQ  in  1  read request, level; one word consumed per grant
RD_DATA  out  16  read word, valid with RD_VALID, held until next read
RD_VALID  out  1  one-cycle pulse
EMPTY  out  1  fill == 0
FILL_CNT  out  DEPTH_BITS+1  words stored
SRAM_A  out  DEPTH_BITS  SRAM address
SRAM_IO_I  in  16  SRAM data bus input
SRAM_IO_O  out  16  SRAM data bus drive value
SRAM_IO_T  out  1  1 = data bus tristated
SRAM_WE_B, SRAM_OE_B, SRAM_CE1_B, SRAM_BHE_B, SRAM_BLE_B  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (BUS_RST or SOFT_RST, either high at a clock edge) takes precedence over everything. At the next edge: state IDLE, WE_B=1, OE_B=1, IO_T=1, wr_ptr=rd_ptr=0, FILL_CNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, WR_ACK=0, RD_VALID=0, RD_DATA=0, SRAM_A=0.
- Reset mid-access aborts the access. An aborted write is not acked and does not count.
- CE1_B, BHE_B and BLE_B are tied 0 after reset. They are 1 during reset cycles.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_ADDR, RD_CAPT.
- IDLE arbitration:
  - Write is eligible when WR_REQ && !FULL. Read is eligible when RD_REQ && !EMPTY.
  - If only one side is eligible, it wins.
  - If both are eligible, grant alternates: the side not granted last wins. After reset the last grant counts as write, so the first tie goes to read.
  - If neither is eligible, the FSM stays in IDLE with OE_B=1, WE_B=1, IO_T=1.
- Write sequence (3 cycles):
  - WR_SETUP: SRAM_A=wr_ptr, IO_O=WR_DATA, IO_T=0, WE_B=1.
  - WR_STROBE: WE_B=0, address and data unchanged.
  - WR_HOLD: WE_B=1, IO_T still 0, WR_ACK=1, wr_ptr increments (wraps 2^DEPTH_BITS-1 -> 0). Then IDLE.
  - Result: WE_B is low exactly one cycle, and address/data are stable one cycle either side of it.
- Read sequence:
  - RD_ADDR: SRAM_A=rd_ptr, IO_T=1, OE_B=0.
  - RD_CAPT: OE_B=0; RD_DATA is registered from SRAM_IO_I at the end of this cycle. rd_ptr increments with wrap.
  - RD_VALID pulses in the cycle after RD_CAPT (IDLE). Latency: grant in IDLE at cycle t gives RD_VALID at t+3.
- IO_T is never 0 while OE_B is 0.
- FILL_CNT: +1 in WR_HOLD, -1 in RD_CAPT. Only one access is in flight, so these never coincide.
- FULL, EMPTY and ALMOST_FULL are registered from the updated count in the same edge as the count.
- FULL write side: backpressure. WR_REQ stays pending and no ack is given until a read frees space.
- EMPTY read side: RD_REQ is ignored. RD_VALID never pulses on an empty FIFO.
- Sustained throughput with both sides requesting: 1 write + 1 read per 7 cycles.

Optional Feature:
SRAM_FIFO_DROP_ON_FULL_EN
- Defined:
  - A WR_REQ seen in IDLE while FULL is acked immediately: WR_ACK pulses on the next cycle, no SRAM access, the word is discarded.
  - LOST_CNT (out, 8) increments and saturates at 255. It clears on reset.
  - The writer never stalls.
- Undefined: backpressure as described in Behaviour; no LOST_CNT port.

Test Plan:
- Reset, then 4 writes 16'h0001..0004, then 4 reads -> WR_ACK pulses 3 cycles after each grant; RD_DATA 1,2,3,4 each at grant+3; FILL_CNT 4 -> 0; EMPTY=1.
- WR_REQ and RD_REQ held high with 2 words preloaded -> grants alternate R,W,R,W starting with read; WE_B low exactly 1 cycle per write; IO_T=1 whenever OE_B=0.
- DEPTH_BITS=4: write 16 words -> FULL=1, ALMOST_FULL=1 from fill 0 with margin 16; 17th WR_REQ is not acked; one read -> 17th write acked at SRAM_A=0 (wrap).
- Pointer wrap: 40 interleaved writes/reads with DEPTH_BITS=4 -> data order preserved; SRAM_A sequence wraps 15 -> 0.
- Assert SOFT_RST during WR_STROBE -> next edge WE_B=1, IO_T=1, no WR_ACK, FILL_CNT=0, EMPTY=1.
- With SRAM_FIFO_DROP_ON_FULL_EN and DEPTH_BITS=4, 20 writes with no reads -> 20 acks, LOST_CNT=4, FILL_CNT=16.
